// File: rtl/logical_tile_io_bank.sv
// Multi-channel GPIO logical tile: per-channel 4-bit config loaded through the ccff chain,
// programmable drive/OE source, optional output register, input synchroniser and inversion.
module logical_tile_io_bank #(
    parameter int N_IO        = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic            prog_clk,
    input  logic            pReset_n,
    input  logic            config_en,
    input  logic            ccff_head,
    output logic            ccff_tail,
    output logic            config_done,
    input  logic [N_IO-1:0] io_outpad,
    input  logic [N_IO-1:0] io_oe,
    output logic [N_IO-1:0] io_inpad,
    inout  wire  [N_IO-1:0] gfpga_pad_GPIO_PAD
);
    localparam int CFG_BITS = 4;
    localparam int TOTAL    = N_IO * CFG_BITS;
    localparam int CW       = $clog2(TOTAL + 1);

    logic [TOTAL-1:0] sr;
    logic [CW-1:0]    cfg_cnt;
    logic [CW-1:0]    cnt_next;
    logic [N_IO-1:0]  data_q;
    logic [N_IO-1:0]  oe_q;
    logic [N_IO-1:0]  pad_sync;
    logic             safe;

    always_comb begin
        cnt_next = cfg_cnt;
        if (config_en && (cfg_cnt != CW'(TOTAL))) begin
            cnt_next = cfg_cnt + CW'(1);
        end
    end

    // config_done is loaded from the next count so it rises on the TOTAL-th shift edge itself
    always_ff @(posedge prog_clk) begin
        if (!pReset_n) begin
            sr          <= '0;
            cfg_cnt     <= '0;
            config_done <= 1'b0;
        end else begin
            if (config_en) begin
                sr <= {sr[TOTAL-2:0], ccff_head};
            end
            cfg_cnt     <= cnt_next;
            config_done <= (cnt_next == CW'(TOTAL));
        end
    end

    assign ccff_tail = sr[TOTAL-1];
    assign safe      = config_en || !config_done;

    always_ff @(posedge prog_clk) begin
        if (!pReset_n) begin
            data_q <= '0;
            oe_q   <= '0;
        end else begin
            data_q <= io_outpad;
            oe_q   <= io_oe;
        end
    end

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign pad_sync = gfpga_pad_GPIO_PAD;
        end else begin : g_sync
            logic [N_IO-1:0] sync_q [SYNC_STAGES];

            always_ff @(posedge prog_clk) begin
                if (!pReset_n) begin
                    for (int unsigned s = 0; s < SYNC_STAGES; s++) begin
                        sync_q[s] <= '0;
                    end
                end else begin
                    sync_q[0] <= gfpga_pad_GPIO_PAD;
                    for (int unsigned s = 1; s < SYNC_STAGES; s++) begin
                        sync_q[s] <= sync_q[s-1];
                    end
                end
            end

            assign pad_sync = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    // cfg bits: [0] dir_en, [1] oe_src, [2] out_reg, [3] in_inv
    for (genvar i = 0; i < N_IO; i++) begin : g_ch
        logic [CFG_BITS-1:0] cfg;
        logic                data;
        logic                oe_sel;
        logic                drive;

        assign cfg = sr[CFG_BITS*i +: CFG_BITS];

        always_comb begin
            data   = cfg[2] ? data_q[i] : io_outpad[i];
            oe_sel = cfg[2] ? oe_q[i]   : io_oe[i];
            drive  = !safe && cfg[0] && (!cfg[1] || oe_sel);
        end

        assign gfpga_pad_GPIO_PAD[i] = drive ? data : 1'bz;
        assign io_inpad[i]           = !safe && (pad_sync[i] ^ cfg[3]);
    end

endmodule

// File: tb/tb_logical_tile_io_bank.sv
// Bench for logical_tile_io_bank: SYNC_STAGES=2 and SYNC_STAGES=0 instances share stimulus;
// a behavioural model is compared every cycle, plus hand-computed directed checks.
module tb_logical_tile_io_bank;
    localparam int N     = 4;
    localparam int TOTAL = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         cfg_en;
    logic         head;
    logic [N-1:0] outpad;
    logic [N-1:0] oe;
    logic [N-1:0] ext_en;
    logic [N-1:0] ext_val;

    wire  [N-1:0] pad_a;
    wire  [N-1:0] pad_b;
    logic         tail_a, done_a, tail_b, done_b;
    logic [N-1:0] inpad_a, inpad_b;

    int tests = 0;
    int fails = 0;
    logic chk_on = 1'b0;

    logical_tile_io_bank #(.N_IO(N), .SYNC_STAGES(2)) dut_a (
        .prog_clk(clk), .pReset_n(rst_n), .config_en(cfg_en), .ccff_head(head),
        .ccff_tail(tail_a), .config_done(done_a), .io_outpad(outpad), .io_oe(oe),
        .io_inpad(inpad_a), .gfpga_pad_GPIO_PAD(pad_a)
    );

    logical_tile_io_bank #(.N_IO(N), .SYNC_STAGES(0)) dut_b (
        .prog_clk(clk), .pReset_n(rst_n), .config_en(cfg_en), .ccff_head(head),
        .ccff_tail(tail_b), .config_done(done_b), .io_outpad(outpad), .io_oe(oe),
        .io_inpad(inpad_b), .gfpga_pad_GPIO_PAD(pad_b)
    );

    // Pulldowns make an undriven pad read 0, so Z is observed with io_outpad=1
    for (genvar i = 0; i < N; i++) begin : g_pad
        assign pad_a[i] = ext_en[i] ? ext_val[i] : 1'bz;
        assign pad_b[i] = ext_en[i] ? ext_val[i] : 1'bz;
        pulldown pd_a (pad_a[i]);
        pulldown pd_b (pad_b[i]);
    end

    // ---------------- behavioural model ----------------
    logic [15:0]  m_sr  = '0;
    int           m_cnt = 0;
    logic [N-1:0] m_dq  = '0;
    logic [N-1:0] m_oq  = '0;
    logic [N-1:0] m_h1  = '0;
    logic [N-1:0] m_h2  = '0;

    function automatic logic m_safe();
        return cfg_en || (m_cnt != TOTAL);
    endfunction

    function automatic logic [N-1:0] model_pad();
        logic [N-1:0] p;
        logic [3:0]   c;
        logic         d, o;
        for (int i = 0; i < N; i++) begin
            c = m_sr[4*i +: 4];
            d = c[2] ? m_dq[i] : outpad[i];
            o = c[2] ? m_oq[i] : oe[i];
            if (!m_safe() && c[0] && (!c[1] || o)) p[i] = d;
            else p[i] = ext_en[i] ? ext_val[i] : 1'b0;
        end
        return p;
    endfunction

    function automatic logic [N-1:0] model_inpad(input int sync, input logic [N-1:0] pnow);
        logic [N-1:0] inv;
        logic [N-1:0] src;
        inv = {m_sr[15], m_sr[11], m_sr[7], m_sr[3]};
        src = (sync == 0) ? pnow : m_h2;
        return m_safe() ? '0 : (src ^ inv);
    endfunction

    always @(posedge clk) begin
        logic [N-1:0] p;
        p = model_pad();
        if (!rst_n) begin
            m_sr = '0; m_cnt = 0; m_dq = '0; m_oq = '0; m_h1 = '0; m_h2 = '0;
        end else begin
            m_h2 = m_h1;
            m_h1 = p;
            m_dq = outpad;
            m_oq = oe;
            if (cfg_en) begin
                m_sr = {m_sr[14:0], head};
                if (m_cnt < TOTAL) m_cnt++;
            end
        end
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        logic [N-1:0] p;
        if (chk_on) begin
            p = model_pad();
            chk("tail_a",  16'(tail_a),  16'(m_sr[15]));
            chk("done_a",  16'(done_a),  16'(m_cnt == TOTAL));
            chk("pad_a",   16'(pad_a),   16'(p));
            chk("inpad_a", 16'(inpad_a), 16'(model_inpad(2, p)));
            chk("tail_b",  16'(tail_b),  16'(m_sr[15]));
            chk("done_b",  16'(done_b),  16'(m_cnt == TOTAL));
            chk("pad_b",   16'(pad_b),   16'(p));
            chk("inpad_b", 16'(inpad_b), 16'(model_inpad(0, p)));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic shift_word(input logic [15:0] w);
        cfg_en = 1'b1;
        for (int k = 15; k >= 0; k--) begin
            head = w[k];
            tick();
        end
    endtask

    // ---------------- directed stimulus ----------------
    logic [15:0] pat;
    logic [N-1:0] idle_out [4];

    initial begin
        rst_n = 1'b0; cfg_en = 1'b0; head = 1'b0;
        outpad = '0; oe = '0; ext_en = '0; ext_val = '0;
        idle_out[0] = 4'hF; idle_out[1] = 4'h0; idle_out[2] = 4'hA; idle_out[3] = 4'h5;
        repeat (2) tick();
        chk_on = 1'b1;

        // reset then idle: pads Z regardless of fabric inputs
        rst_n = 1'b1;
        for (int j = 0; j < 4; j++) begin
            outpad = idle_out[j];
            oe     = ~idle_out[j];
            tick();
            outpad = 4'hF;
            #1;
            chk("idle_pad",   16'(pad_a),   16'h0);
            chk("idle_inpad", 16'(inpad_a), 16'h0);
            chk("idle_tail",  16'(tail_a),  16'h0);
            chk("idle_done",  16'(done_a),  16'h0);
        end
        outpad = '0; oe = '0;

        // shift-through of A5C3
        pat    = 16'hA5C3;
        cfg_en = 1'b1;
        for (int k = 15; k >= 1; k--) begin
            head = pat[k];
            tick();
        end
        chk("done_after_15", 16'(done_a), 16'h0);
        head = pat[0];
        tick();
        chk("done_after_16", 16'(done_a), 16'h1);
        chk("tail_edge16",   16'(tail_a), 16'h1);
        head = 1'b0;
        for (int j = 1; j < 16; j++) begin
            tick();
            chk("tail_seq", 16'(tail_a), 16'(pat[15-j]));
        end

        // modes: ch3=1000 ch2=0101 ch1=0011 ch0=0001
        rst_n = 1'b0; cfg_en = 1'b0; tick();
        rst_n = 1'b1;
        shift_word(16'h8531);
        cfg_en = 1'b0;
        #1;
        chk("ch0_low", 16'(pad_a[0]), 16'h0);
        outpad[0] = 1'b1;
        #1;
        chk("ch0_comb",     16'(pad_a[0]),   16'h1);
        chk("sync0_inpad0", 16'(inpad_b[0]), 16'h1);

        tick();
        outpad[1] = 1'b1; oe[1] = 1'b0;
        #1;
        chk("ch1_oe0_z", 16'(pad_a[1]), 16'h0);
        oe[1] = 1'b1;
        #1;
        chk("ch1_oe1_drive", 16'(pad_a[1]), 16'h1);

        tick();
        outpad[2] = 1'b1;
        #1;
        chk("ch2_same_cycle", 16'(pad_a[2]), 16'h0);
        tick();
        chk("ch2_next_cycle", 16'(pad_a[2]), 16'h1);
        outpad[2] = 1'b0;
        #1;
        chk("ch2_hold", 16'(pad_a[2]), 16'h1);
        tick();
        chk("ch2_fall", 16'(pad_a[2]), 16'h0);

        ext_en[3] = 1'b1; ext_val[3] = 1'b1;
        #1;
        chk("ch3_inv_before", 16'(inpad_a[3]), 16'h1);
        chk("ch3_sync0_inv",  16'(inpad_b[3]), 16'h0);
        tick();
        chk("ch3_after_1", 16'(inpad_a[3]), 16'h1);
        tick();
        chk("ch3_after_2", 16'(inpad_a[3]), 16'h0);

        // safe state on config_en reassertion, released immediately on deassertion
        tick();
        cfg_en = 1'b1;
        #1;
        chk("safe_pad",     16'(pad_a & 4'b0111), 16'h0);
        chk("safe_inpad_a", 16'(inpad_a),         16'h0);
        chk("safe_inpad_b", 16'(inpad_b),         16'h0);
        cfg_en = 1'b0;
        #1;
        chk("unsafe_pad0",   16'(pad_a[0]),   16'h1);
        chk("unsafe_inpadb", 16'(inpad_b[0]), 16'h1);
        tick();
        ext_en = '0;

        // reset mid-load discards the partial configuration
        rst_n = 1'b0; tick();
        rst_n = 1'b1; cfg_en = 1'b1; head = 1'b1;
        repeat (9) tick();
        rst_n = 1'b0; tick();
        rst_n = 1'b1;
        chk("midrst_done", 16'(done_a), 16'h0);
        chk("midrst_tail", 16'(tail_a), 16'h0);
        repeat (15) tick();
        chk("reload15_done", 16'(done_a), 16'h0);
        chk("reload15_tail", 16'(tail_a), 16'h0);
        tick();
        chk("reload16_done", 16'(done_a), 16'h1);
        chk("reload16_tail", 16'(tail_a), 16'h1);
        cfg_en = 1'b0; head = 1'b0;
        repeat (4) tick();

        // reset has priority over config_en
        rst_n = 1'b0; cfg_en = 1'b1; head = 1'b1;
        repeat (17) tick();
        chk("rstprio_tail_b", 16'(tail_b), 16'h0);
        chk("rstprio_done_b", 16'(done_b), 16'h0);
        chk("rstprio_tail_a", 16'(tail_a), 16'h0);
        rst_n = 1'b1; cfg_en = 1'b0; head = 1'b0;
        repeat (2) tick();

        chk_on = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/logical_tile_io_bank.md
# logical_tile_io_bank

Parametrised multi-channel GPIO logical tile. It replaces the single-pad, fixed-direction io tile with N_IO independently configured pads. Each pad has a per-channel configuration word loaded through the ccff chain, a programmable direction and output-enable source, an optional output register, a selectable input synchroniser and input inversion. It sits at the fabric periphery between the routing fabric and the gfpga_pad_GPIO_PAD pins, and is chained into the global configuration shift path like every other tile.

## Interface
Parameters:
- N_IO, default 4: number of pad channels, valid range 1..32.
- SYNC_STAGES, default 2: number of input synchroniser flops, valid values 0..3; 0 means the input path is combinational.
- CFG_BITS, fixed at 4: configuration bits per channel; not overridable.

Ports:
- prog_clk, input, 1: the single clock for both the configuration chain and the datapath.
- pReset_n, input, 1: reset, synchronous and active-low.
- config_en, input, 1: shift-enable for the configuration chain.
- ccff_head, input, 1: serial configuration input.
- ccff_tail, output, 1: serial configuration output.
- config_done, output, 1: high once N_IO*CFG_BITS bits have been shifted since reset.
- io_outpad, input, N_IO: fabric-to-pad data.
- io_oe, input, N_IO: fabric output-enable, used only when a channel is in oe_src=1 mode.
- io_inpad, output, N_IO: pad-to-fabric data.
- gfpga_pad_GPIO_PAD, inout, N_IO: physical pads.

## Operation
- Configuration register sr is TOTAL = N_IO*4 bits.
  - On a cycle with config_en=1: sr <= {sr[TOTAL-2:0], ccff_head}.
  - ccff_tail = sr[TOTAL-1], registered.
- Channel i uses cfg = sr[4i+3:4i]:
  - bit0 dir_en: 0 means input only, pad is Z.
  - bit1 oe_src: 0 means drive whenever dir_en=1; 1 means drive when dir_en=1 and io_oe[i]=1.
  - bit2 out_reg: 1 means io_outpad[i] and io_oe[i] each pass through one flop before reaching the pad.
  - bit3 in_inv: 1 means io_inpad[i] is the inverted synchronised pad value.
- Bit-load counter cfg_cnt, width clog2(TOTAL+1):
  - Increments on every config_en cycle and saturates at TOTAL.
  - config_done = (cfg_cnt == TOTAL), registered.
  - Shifting past TOTAL continues to move bits out of ccff_tail; config_done stays 1.
- Safe state: while config_en=1 or config_done=0, every pad is Z and io_inpad is forced to all zeros, regardless of sr.
- Drive: pad[i] = drive_i ? data_i : 1'bz.
  - data_i and drive_i come from flopped versions when out_reg=1, direct inputs otherwise.
- Input: pad[i] goes through SYNC_STAGES flops, then the optional inversion, then the safe-state gate, then io_inpad[i].
- A driving pad reads back its own driven value; this is legal loopback.

## Timing
- Reset (pReset_n=0 at a prog_clk edge) clears, at that edge:
  - sr, cfg_cnt, ccff_tail, config_done, the out_reg flops and the synchroniser flops all go to 0.
  - Result: all pads Z, io_inpad=0.
- Reset has priority over config_en in the same cycle.
- Reset during a load discards partial configuration; the full TOTAL bits must be reshifted.
- Chain latency: the bit presented on ccff_head at edge k appears on ccff_tail after edge k+TOTAL-1, counting config_en cycles only.
- config_done rises on the edge that performs the TOTAL-th shift.
- The safe-state release takes effect on the first cycle in which config_en=0 and config_done=1. There is no extra cycle.
- Output latency, fabric to pad:
  - out_reg=0: 0 cycles (combinational).
  - out_reg=1: 1 cycle.
- Input latency, pad to io_inpad: SYNC_STAGES cycles. The inversion and the gate are combinational after the last flop.
- Deasserting config_en mid-load freezes sr and cfg_cnt; loading resumes when config_en is reasserted.

## Test plan
- Reset then idle, N_IO=4:
  - Required: ccff_tail=0, config_done=0, all pads Z, io_inpad=4'b0000.
  - Toggling io_outpad and io_oe has no effect on the pads.
- Shift-through:
  - Stimulus: config_en=1, drive the 16-bit pattern 16'hA5C3 MSB-first.
  - Required: config_done rises on the 16th edge. Continued shifting of zeros returns A,5,C,3 nibbles on ccff_tail, MSB-first, starting at edge 16.
- Modes after load:
  - Configuration: ch0 cfg=0001, ch1 cfg=0011, ch2 cfg=0101, ch3 cfg=1000.
  - Required at ch0: pad follows io_outpad[0] in the same cycle.
  - Required at ch1: pad is Z when io_oe[1]=0 and driven when io_oe[1]=1.
  - Required at ch2: pad follows io_outpad[2] one cycle late.
  - Required at ch3: external pad=1 gives io_inpad[3]=0 after 2 cycles.
- Safe state: reassert config_en after a load.
  - Required: all pads go to Z and io_inpad=0 in the same cycle.
  - Deasserting config_en restores the previous behaviour immediately.
- Reset mid-load: assert pReset_n=0 after 9 shifts.
  - Required: cfg_cnt and sr are cleared. A further 16 shifts are needed before config_done=1.
- SYNC_STAGES=0 build:
  - Required: a pad transition reaches io_inpad combinationally.
  - Required: pReset_n=0 together with config_en=1 leaves sr unchanged at 0.
